// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing for the sequential divider
package div_pkg;
  localparam int DIV_WIDTH = 64;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, FIN} div_state_t;
endpackage

// File: rtl/fullAddSub_64.sv
// rtl/fullAddSub_64.sv - 64-bit add/subtract datapath (sub=1 computes a - b)
module fullAddSub_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        sub,
  output logic [63:0] sum,
  output logic        carry_out,
  output logic        overflow
);
  logic [63:0] b_eff;
  logic [64:0] full;

  // Two's complement subtraction: invert b and inject sub as carry-in
  assign b_eff     = b ^ {64{sub}};
  assign full      = {1'b0, a} + {1'b0, b_eff} + {64'd0, sub};
  assign sum       = full[63:0];
  assign carry_out = full[64];
  assign overflow  = (a[63] == b_eff[63]) && (sum[63] != a[63]);
endmodule

// File: rtl/addsub_divider_seq.sv
// rtl/addsub_divider_seq.sv - restoring unsigned divider, one trial subtraction per clock
module addsub_divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  div_state_t       state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             sub_ovf_unused;
  logic             qbit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // The partial remainder's top bit is always 0 between iterations, so only the low bits are stored
  assign s = {r_reg, q_reg[WIDTH-1]};

  fullAddSub_64 u_addsub (
    .a         (s[WIDTH-1:0]),
    .b         (d_reg),
    .sub       (1'b1),
    .sum       (diff),
    .carry_out (carry),
    .overflow  (sub_ovf_unused)
  );

  // s[WIDTH] set means s exceeds any WIDTH-bit divisor even though the low-bit subtract borrowed
  assign qbit   = carry | s[WIDTH];
  assign r_next = qbit ? diff : s[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], qbit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state     <= FIN;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              q_reg <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state     <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
            div_zero  <= 1'b0;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_divider_seq.sv
// tb/tb_addsub_divider_seq.sv - randomized self-checking bench against a quotient/remainder model
module tb_addsub_divider_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_zero;

  addsub_divider_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;
  int busy_cycles = 0;

  // Reference: 0 idle, 1 computing (64 cycles), 2 result cycle; results from / and %
  int          m_phase = 0;
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz = 1'b0;
  logic [63:0] m_q = '0;
  logic [63:0] m_r = '0;
  logic [63:0] p_q = '0;
  logic [63:0] p_r = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
      m_dz = 1'b0; m_q = '0; m_r = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (divisor == 64'd0) begin
            m_phase = 2; m_done = 1'b1; m_q = '1; m_r = dividend; m_dz = 1'b1;
          end else begin
            m_phase = 1; m_left = 64; m_busy = 1'b1;
            p_q = dividend / divisor;
            p_r = dividend % divisor;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_busy = 1'b0; m_done = 1'b1;
            m_q = p_q; m_r = p_r; m_dz = 1'b0;
          end
        end
        default: begin
          m_phase = 0; m_done = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_zero", 64'(div_zero), 64'(m_dz));
    if (done) done_pulses++;
    if (busy) busy_cycles++;
  end

  task automatic run_div(input logic [63:0] a, input logic [63:0] b, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 64'(lat), 64'd0);
  endtask

  initial begin
    int          lat;
    int          base;
    logic [63:0] a;
    logic [63:0] b;
    logic [127:0] prod;

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // abort mid-run with an asynchronous reset
    start = 1'b1; dividend = 64'd100; divisor = 64'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    base = done_pulses;
    repeat (80) @(negedge clk);
    chk("rst_no_done", 64'(done_pulses), 64'(base));
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);

    // basic 100/7
    busy_cycles = 0;
    run_div(64'd100, 64'd7, lat);
    chk("basic_latency", 64'(lat), 64'd65);
    chk("basic_q", quotient, 64'd14);
    chk("basic_r", remainder, 64'd2);
    chk("basic_dz", 64'(div_zero), 64'd0);
    chk("model_basic_q", m_q, 64'd14);
    chk("basic_busy_cycles", 64'(busy_cycles), 64'd64);
    @(negedge clk);

    // divide by zero
    run_div(64'hDEAD, 64'd0, lat);
    chk("dz_latency", 64'(lat), 64'd1);
    chk("dz_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dz_r", remainder, 64'hDEAD);
    chk("dz_flag", 64'(div_zero), 64'd1);
    @(negedge clk);

    // divisor above 2^63 exercises the shifted-out top bit
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, lat);
    chk("large_q", quotient, 64'd1);
    chk("large_r", remainder, 64'h7FFF_FFFF_FFFF_FFFE);
    chk("model_large_r", m_r, 64'h7FFF_FFFF_FFFF_FFFE);
    @(negedge clk);

    run_div(64'd5, 64'd9, lat);
    chk("small_q", quotient, 64'd0);
    chk("small_r", remainder, 64'd5);
    @(negedge clk);

    run_div(64'h0123_4567_89AB_CDEF, 64'd1, lat);
    chk("one_q", quotient, 64'h0123_4567_89AB_CDEF);
    chk("one_r", remainder, 64'd0);
    @(negedge clk);

    // start during a run must be dropped
    base = done_pulses;
    start = 1'b1; dividend = 64'd100; divisor = 64'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1; dividend = 64'd50; divisor = 64'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore_q", quotient, 64'd14);
    chk("ignore_r", remainder, 64'd2);
    repeat (5) @(negedge clk);
    chk("ignore_pulses", 64'(done_pulses - base), 64'd1);
    chk("ignore_idle_busy", 64'(busy), 64'd0);
    run_div(64'd50, 64'd5, lat);
    chk("after_q", quotient, 64'd10);
    chk("after_r", remainder, 64'd0);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 40);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (b == 64'd0) b = 64'd1;
      run_div(a, b, lat);
      prod = 128'(quotient) * 128'(b) + 128'(remainder);
      chk("rand_identity", prod[63:0] ^ 64'(prod[127:64] != 0), a);
      chk("rand_r_lt_d", 64'(remainder < b), 64'd1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
